// File: rtl/cam_pixel_pack_if.sv
// cam_pixel_pack_if
// Write-side bus between the camera packer and the SDRAM write FIFO.
//   fifo_data    : packed 16-bit word, {first byte, second byte}
//   fifo_wrreq   : single-cycle write strobe
//   fifo_wrusedw : write-side usage of the FIFO, used to gate writes
// Modports:
//   master : the packer (drives data/strobe, reads usage)
//   slave  : the FIFO side (reads data/strobe, drives usage)
interface cam_pixel_pack_if;
  logic [15:0] fifo_data;
  logic        fifo_wrreq;
  logic [8:0]  fifo_wrusedw;

  modport master (output fifo_data, output fifo_wrreq, input fifo_wrusedw);
  modport slave  (input fifo_data, input fifo_wrreq, output fifo_wrusedw);
endinterface

// File: rtl/cam_pixel_pack.sv
// cam_pixel_pack
// DVP camera capture front end. Samples PCLK/VSYNC/HREF/D in the S_CLK
// domain, packs byte pairs into 16-bit RGB565 words and strobes them into
// the SDRAM write FIFO, dropping words while the FIFO is near full.
// Ports:
//   S_CLK, RST_N          : system clock, async active-low reset
//   cam_pclk/vsync/href   : raw camera controls (asynchronous)
//   cam_data[7:0]         : raw pixel byte
//   wr_if (master)        : fifo_data / fifo_wrreq / fifo_wrusedw
//   frame_start/done      : one-cycle frame markers
//   word_cnt              : words written in current/last frame (saturating)
//   overflow, line_err    : sticky per-frame error flags
// Build option: CAM_TEST_PATTERN_EN replaces packed camera data with a
// per-frame incrementing 16-bit counter; everything else is unchanged.
module cam_pixel_pack #(
  parameter int SKIP_FRAMES  = 10,
  parameter int FIFO_FULL_TH = 500,
  parameter int WORD_CNT_W   = 20
) (
  input  logic                  S_CLK,
  input  logic                  RST_N,
  input  logic                  cam_pclk,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_data,
  cam_pixel_pack_if.master      wr_if,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic [WORD_CNT_W-1:0] word_cnt,
  output logic                  overflow,
  output logic                  line_err
);

  typedef enum logic [1:0] {
    WAIT_VS  = 2'd0,
    SKIP     = 2'd1,
    WAIT_ACT = 2'd2,
    ACTIVE   = 2'd3
  } state_t;

  // One spare count value so the counter never needs to exceed its width.
  localparam int                SKIP_W    = $clog2(SKIP_FRAMES + 2);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES);
  localparam logic [9:0]        FULL_TH   = 10'(FIFO_FULL_TH);

  // Stage 1/2 are the synchroniser, stage 3 is the delayed copy for edges.
  logic                  pclk_s1_r, pclk_s2_r, pclk_s3_r;
  logic                  vs_s1_r, vs_s2_r, vs_s3_r;
  logic                  href_s1_r, href_s2_r, href_s3_r;
  logic [7:0]            data_s1_r, data_s2_r, data_s3_r;
  logic                  pclk_rise_r, vs_rise_r, vs_fall_r, href_fall_r;

  state_t                state_r, state_nxt_s;
  logic [SKIP_W-1:0]     skip_cnt_r, skip_cnt_nxt_s;
  logic                  phase_r, phase_nxt_s;
  logic                  start_s, done_s, latch_hi_s, word_s, lerr_s;
  logic                  fifo_ok_s, write_s, drop_s;

  logic [7:0]            hi_r;
  logic [15:0]           fifo_data_r;
  logic                  fifo_wrreq_r, frame_start_r, frame_done_r;
  logic                  overflow_r, line_err_r;
  logic [WORD_CNT_W-1:0] word_cnt_r;

  // Synchronise camera inputs and register their edges; data and href
  // travel through the same stages so stage 3 lines up with pclk_rise_r.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      {pclk_s1_r, pclk_s2_r, pclk_s3_r} <= 3'b000;
      {vs_s1_r, vs_s2_r, vs_s3_r}       <= 3'b000;
      {href_s1_r, href_s2_r, href_s3_r} <= 3'b000;
      data_s1_r   <= 8'h00;
      data_s2_r   <= 8'h00;
      data_s3_r   <= 8'h00;
      pclk_rise_r <= 1'b0;
      vs_rise_r   <= 1'b0;
      vs_fall_r   <= 1'b0;
      href_fall_r <= 1'b0;
    end else begin
      {pclk_s1_r, pclk_s2_r, pclk_s3_r} <= {cam_pclk, pclk_s1_r, pclk_s2_r};
      {vs_s1_r, vs_s2_r, vs_s3_r}       <= {cam_vsync, vs_s1_r, vs_s2_r};
      {href_s1_r, href_s2_r, href_s3_r} <= {cam_href, href_s1_r, href_s2_r};
      data_s1_r   <= cam_data;
      data_s2_r   <= data_s1_r;
      data_s3_r   <= data_s2_r;
      pclk_rise_r <= pclk_s2_r & ~pclk_s3_r;
      vs_rise_r   <= vs_s2_r & ~vs_s3_r;
      vs_fall_r   <= ~vs_s2_r & vs_s3_r;
      href_fall_r <= ~href_s2_r & href_s3_r;
    end
  end

  // FSM state, skip counter and byte phase registers.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= WAIT_VS;
      skip_cnt_r <= '0;
      phase_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      skip_cnt_r <= skip_cnt_nxt_s;
      phase_r    <= phase_nxt_s;
    end
  end

  // Next-state logic plus the per-cycle packing/frame control strobes.
  always_comb begin
    state_nxt_s    = state_r;
    skip_cnt_nxt_s = skip_cnt_r;
    phase_nxt_s    = phase_r;
    start_s        = 1'b0;
    done_s         = 1'b0;
    latch_hi_s     = 1'b0;
    word_s         = 1'b0;
    lerr_s         = 1'b0;
    case (state_r)
      WAIT_VS: begin
        if (vs_rise_r) begin
          skip_cnt_nxt_s = SKIP_W'(1);
          state_nxt_s    = (SKIP_W'(1) >= SKIP_LAST) ? WAIT_ACT : SKIP;
        end else begin
          state_nxt_s = WAIT_VS;
        end
      end
      SKIP: begin
        if (vs_rise_r) begin
          skip_cnt_nxt_s = skip_cnt_r + SKIP_W'(1);
          state_nxt_s    = ((skip_cnt_r + SKIP_W'(1)) >= SKIP_LAST) ? WAIT_ACT : SKIP;
        end else begin
          state_nxt_s = SKIP;
        end
      end
      WAIT_ACT: begin
        if (vs_fall_r) begin
          state_nxt_s = ACTIVE;
          start_s     = 1'b1;
          phase_nxt_s = 1'b0;
        end else begin
          state_nxt_s = WAIT_ACT;
        end
      end
      ACTIVE: begin
        // A vsync rise wins over a coincident byte: the byte is discarded.
        if (vs_rise_r) begin
          state_nxt_s = WAIT_ACT;
          done_s      = 1'b1;
        end else if (pclk_rise_r && href_s3_r) begin
          if (!phase_r) begin
            latch_hi_s  = 1'b1;
            phase_nxt_s = 1'b1;
          end else begin
            word_s      = 1'b1;
            phase_nxt_s = 1'b0;
          end
        end else if (href_fall_r && phase_r) begin
          lerr_s      = 1'b1;
          phase_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      default: begin
        state_nxt_s = WAIT_VS;
      end
    endcase
    // Usage is sampled in the cycle the word forms; no lookahead.
    fifo_ok_s = ({1'b0, wr_if.fifo_wrusedw} < FULL_TH);
    write_s   = word_s & fifo_ok_s;
    drop_s    = word_s & ~fifo_ok_s;
  end

`ifdef CAM_TEST_PATTERN_EN
  logic [15:0] pat_cnt_r;

  // Test-pattern counter: cleared per frame, advanced per accepted write.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      pat_cnt_r <= 16'h0000;
    end else if (start_s) begin
      pat_cnt_r <= 16'h0000;
    end else if (write_s) begin
      pat_cnt_r <= pat_cnt_r + 16'd1;
    end
  end
`endif

  // Output datapath: byte latch, FIFO write, counters, sticky flags, pulses.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      hi_r          <= 8'h00;
      fifo_data_r   <= 16'h0000;
      fifo_wrreq_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      word_cnt_r    <= '0;
      overflow_r    <= 1'b0;
      line_err_r    <= 1'b0;
    end else begin
      frame_start_r <= start_s;
      frame_done_r  <= done_s;
      fifo_wrreq_r  <= write_s;
      if (latch_hi_s) begin
        hi_r <= data_s3_r;
      end
      if (write_s) begin
`ifdef CAM_TEST_PATTERN_EN
        fifo_data_r <= pat_cnt_r;
`else
        fifo_data_r <= {hi_r, data_s3_r};
`endif
      end
      if (start_s) begin
        word_cnt_r <= '0;
        overflow_r <= 1'b0;
        line_err_r <= 1'b0;
      end else begin
        if (write_s && (word_cnt_r != {WORD_CNT_W{1'b1}})) begin
          word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
        end
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
        if (lerr_s) begin
          line_err_r <= 1'b1;
        end
      end
    end
  end

  assign wr_if.fifo_data  = fifo_data_r;
  assign wr_if.fifo_wrreq = fifo_wrreq_r;
  assign frame_start      = frame_start_r;
  assign frame_done       = frame_done_r;
  assign word_cnt         = word_cnt_r;
  assign overflow         = overflow_r;
  assign line_err         = line_err_r;

endmodule

// File: doc/cam_pixel_pack.md
# cam_pixel_pack

Camera capture front end feeding the SDRAM write FIFO. Samples an 8-bit DVP camera bus (PCLK/VSYNC/HREF/D) in the S_CLK domain and packs byte pairs into 16-bit RGB565 words. Emits one-cycle FIFO write strobes, gated by FIFO fill level. Produces frame/line markers and error flags for the downstream SDRAM controller, which starts bursts from the FIFO usage count.

## Interface
Parameters:
- SKIP_FRAMES, 10: complete frames discarded after reset for sensor settling.
- FIFO_FULL_TH, 500: fifo_wrusedw at or above this value causes the packed word to be dropped.
- WORD_CNT_W, 20: width of word_cnt; matches the SDRAM word address width.

Ports:
- S_CLK in 1: system clock; must be ≥3× cam_pclk.
- RST_N in 1: reset, asynchronous, active-low.
- cam_pclk in 1: camera pixel clock, treated as asynchronous data.
- cam_vsync in 1: frame sync, active-high between frames.
- cam_href in 1: line valid.
- cam_data in 8: pixel byte.
- fifo_wrusedw in 9: write-side usage of the write FIFO.
- fifo_data out 16: packed word, {first byte, second byte}.
- fifo_wrreq out 1: single-cycle write strobe.
- frame_start out 1: pulse at start of a captured frame.
- frame_done out 1: pulse at end of a captured frame.
- word_cnt out WORD_CNT_W: words written in the current or last frame.
- overflow out 1: sticky; a word was dropped in this frame.
- line_err out 1: sticky; a line ended on an odd byte in this frame.

## Operation
- Synchronisation: cam_pclk, cam_vsync, cam_href and cam_data each pass through 2 flops. cam_data shares the same stages so it stays aligned.
- PCLK rising edge: detected when the synced value is 1 and its delayed copy is 0. Each detected edge is one byte event. VSYNC edges are detected the same way.
- FSM states:
  - WAIT_VS: wait for a vsync rise.
  - SKIP: count vsync rises up to SKIP_FRAMES.
  - WAIT_ACT: vsync high; wait for vsync fall.
  - ACTIVE: capture.
- Transitions:
  - Reset → WAIT_VS.
  - WAIT_VS, on vsync rise → SKIP with skip_cnt=1. If SKIP_FRAMES=0, go directly to WAIT_ACT.
  - SKIP, on vsync rise: skip_cnt+1. When skip_cnt reaches SKIP_FRAMES → WAIT_ACT.
  - WAIT_ACT, on vsync fall → ACTIVE. On this transition: frame_start pulse; word_cnt, overflow, line_err and the byte phase are cleared.
  - ACTIVE, on vsync rise → WAIT_ACT. On this transition: frame_done pulse; word_cnt is held until the next frame_start.
- Packing (ACTIVE only):
  - A byte event with href=1 and phase=0 latches the high byte and sets phase=1.
  - A byte event with href=1 and phase=1 forms the word and sets phase=0.
  - Byte events with href=0 are ignored.
- Word write:
  - If fifo_wrusedw < FIFO_FULL_TH: fifo_wrreq=1 for one cycle and word_cnt+1.
  - Otherwise: word dropped, overflow set, word_cnt unchanged.
- Line end: href falling with phase=1 → discard the half word, set line_err, phase=0.
- word_cnt saturates at all-ones; it does not wrap.
- Reset values: fifo_data=0, fifo_wrreq=0, frame_start=0, frame_done=0, word_cnt=0, overflow=0, line_err=0; FSM=WAIT_VS; skip_cnt=0; phase=0.
- Reset asserted mid-frame: everything returns to the reset values immediately. The SKIP_FRAMES sequence restarts; no partial word is written.

## Timing
- Edge latency: a cam_pclk rise captured by sync flop 1 at cycle n is detected at cycle n+2. The byte is latched at n+2.
- Word latency: for the second byte, fifo_wrreq and fifo_data are valid at cycle n+3.
- Full check: fifo_wrusedw is sampled at the cycle the word is formed (n+2). No lookahead is applied; FIFO_FULL_TH margin absorbs the write-FIFO usedw latency.
- Pulses: frame_start and frame_done are exactly 1 S_CLK wide and registered. frame_done occurs 3 cycles after the synced vsync rise, in the same cycle word_cnt is final.
- Simultaneous vsync rise and byte event in ACTIVE: the byte is discarded and the frame ends.
- Strobe spacing: consecutive fifo_wrreq are separated by ≥2·(S_CLK/PCLK ratio) cycles; back-to-back strobes never occur.

## Configuration
- CAM_TEST_PATTERN_EN defined:
  - fifo_data is taken from an internal 16-bit counter instead of packed camera bytes. The counter resets to 0 at frame_start and increments after each accepted write.
  - All timing, gating, FSM and flags are unchanged; camera bytes are still counted for phase.
- CAM_TEST_PATTERN_EN undefined: fifo_data carries camera data only, and the counter logic is not synthesised.

## Test plan
- Reset state and skip count:
  - Stimulus: SKIP_FRAMES=2, RST_N low 100 ns, then 3 frames of 4 lines × 8 bytes, PCLK = S_CLK/4.
  - Response: no fifo_wrreq during frames 1–2; frame 3 gives one frame_start, 16 strobes, then frame_done with word_cnt=16.
- Packing order:
  - Stimulus: bytes 0xAB, 0xCD, 0x12, 0x34 on one line.
  - Response: fifo_data=0xABCD, then 0x1234; each fifo_wrreq is 3 cycles after the synced second-byte edge.
- Overflow:
  - Stimulus: hold fifo_wrusedw=500 for 4 words mid-line.
  - Response: those 4 words are not strobed; overflow=1 until the next frame_start; word_cnt is 4 short.
- Odd line:
  - Stimulus: a 7-byte line.
  - Response: 3 words written; line_err=1; the next line starts at phase 0 and packs correctly.
- Reset mid-frame:
  - Stimulus: assert RST_N during ACTIVE after 5 words.
  - Response: all outputs 0 at once; after release, SKIP_FRAMES frames are skipped again.
- Test pattern:
  - Stimulus: CAM_TEST_PATTERN_EN defined, one 8-word frame.
  - Response: fifo_data sequence 0..7; overflow gating still honoured.
